instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/mips_fetch_pkg.sv | 35 +++
 rtl/fetch_pc_sel.sv | 70 +++++++
 rtl/instruction_fetch.sv | 145 ++++++++++++++
 tb/tb_instruction_fetch.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_fetch_pkg.sv
// Shared constants and types for the MIPS fetch stage: vectors, redirect
// encodings, fetch-state enumeration and the per-cycle fetch action.
package mips_fetch_pkg;

  localparam logic [31:0] RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] IRQ_VEC   = 32'h0000_0004;
  localparam logic [31:0] EXC_VEC   = 32'h0000_0008;

  typedef enum logic [1:0] {
    REDIR_SEQ = 2'b00,
    REDIR_BR  = 2'b01,
    REDIR_J   = 2'b10,
    REDIR_JR  = 2'b11
  } redirect_sel_e;

  typedef enum logic [1:0] {
    ST_BOOT   = 2'b00,
    ST_KERNEL = 2'b01,
    ST_USER   = 2'b10
  } fetch_state_e;

  // What the fetch stage does on the coming edge, as chosen by fetch_pc_sel.
  typedef enum logic [2:0] {
    ACT_HOLD  = 3'd0,
    ACT_SEQ   = 3'd1,
    ACT_REDIR = 3'd2,
    ACT_IRQ   = 3'd3,
    ACT_EXC   = 3'd4
  } fetch_action_e;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_pc_sel.sv
// Combinational next-PC selection: resolves exception, interrupt, redirect,
// stall and sequential fetch in priority order and reports the chosen action.
module fetch_pc_sel
  import mips_fetch_pkg::*;
(
  input  logic [1:0]    i_state,
  input  logic          i_stall,
  input  logic [1:0]    i_redirect_sel,
  input  logic [31:0]   i_branch_target,
  input  logic [31:0]   i_jump_target,
  input  logic [31:0]   i_jr_target,
  input  logic          i_irq,
  input  logic          i_exception,
  input  logic [31:0]   i_pc,
  input  logic [31:0]   i_pc_plus4,
  input  logic [31:0]   i_if_id_pc_plus4,
  output logic [31:0]   o_next_pc,
  output fetch_action_e o_action,
  output logic [31:0]   o_epc_value
);

  logic [31:0] w_redirect_target;
  logic        w_redirect;
  logic        w_boot;
  logic        w_user;

  assign w_redirect = (i_redirect_sel != REDIR_SEQ);
  assign w_boot     = (i_state == ST_BOOT);
  assign w_user     = (i_state == ST_USER);

  always_comb begin
    w_redirect_target = i_pc_plus4;
    case (i_redirect_sel)
      REDIR_BR: w_redirect_target = word_align(i_branch_target);
      REDIR_J:  w_redirect_target = word_align(i_jump_target);
      REDIR_JR: w_redirect_target = word_align(i_jr_target);
      default:  w_redirect_target = i_pc_plus4;
    endcase
  end

  // BOOT performs exactly one plain fetch from RESET_VEC; every event is
  // ignored there so the reset vector is always the first word fetched.
  always_comb begin
    o_next_pc   = i_pc;
    o_action    = ACT_HOLD;
    o_epc_value = i_pc;
    if (w_boot) begin
      o_next_pc = i_pc_plus4;
      o_action  = ACT_SEQ;
    end else if (i_exception) begin
      o_next_pc   = EXC_VEC;
      o_action    = ACT_EXC;
      o_epc_value = i_if_id_pc_plus4;
    end else if (i_irq && w_user) begin
      o_next_pc   = IRQ_VEC;
      o_action    = ACT_IRQ;
      o_epc_value = w_redirect ? w_redirect_target : i_pc;
    end else if (w_redirect) begin
      o_next_pc = w_redirect_target;
      o_action  = ACT_REDIR;
    end else if (i_stall) begin
      o_next_pc = i_pc;
      o_action  = ACT_HOLD;
    end else begin
      o_next_pc = i_pc_plus4;
      o_action  = ACT_SEQ;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// MIPS instruction fetch stage: PC register, BOOT/KERNEL/USER mode FSM,
// IF/ID pipeline register and EPC capture on interrupt/exception entry.
module instruction_fetch
  import mips_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        Stall,
  input  logic [1:0]  RedirectSel,
  input  logic [31:0] BranchTarget,
  input  logic [31:0] JumpTarget,
  input  logic [31:0] JrTarget,
  input  logic        IRQ,
  input  logic        Exception,
  output logic [31:0] Address,
  input  logic [31:0] Instruction,
  output logic [31:0] IF_ID_Instruction,
  output logic [31:0] IF_ID_PCPlus4,
  output logic        IF_ID_Valid,
  output logic [31:0] EPC,
  output logic        EPCWrite,
  output logic        KernelMode
);

  fetch_state_e  r_state;
  fetch_state_e  w_state_next;
  logic [31:0]   r_pc;
  logic [31:0]   r_if_id_instr;
  logic [31:0]   r_if_id_pc_plus4;
  logic          r_if_id_valid;
  logic [31:0]   r_epc;
  logic          r_epc_write;

  logic [31:0]   w_pc_plus4;
  logic [31:0]   w_next_pc;
  logic [31:0]   w_epc_value;
  fetch_action_e w_action;

  assign w_pc_plus4 = r_pc + 32'd4;

  fetch_pc_sel u_pc_sel (
    .i_state          (r_state),
    .i_stall          (Stall),
    .i_redirect_sel   (RedirectSel),
    .i_branch_target  (BranchTarget),
    .i_jump_target    (JumpTarget),
    .i_jr_target      (JrTarget),
    .i_irq            (IRQ),
    .i_exception      (Exception),
    .i_pc             (r_pc),
    .i_pc_plus4       (w_pc_plus4),
    .i_if_id_pc_plus4 (r_if_id_pc_plus4),
    .o_next_pc        (w_next_pc),
    .o_action         (w_action),
    .o_epc_value      (w_epc_value)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_BOOT;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Only a jr that actually wins priority drops KERNEL into USER; an
  // exception arriving alongside it keeps the FSM in KERNEL.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_BOOT: begin
        w_state_next = ST_KERNEL;
      end
      ST_KERNEL: begin
        if (w_action == ACT_REDIR && RedirectSel == REDIR_JR) begin
          w_state_next = ST_USER;
        end
      end
      ST_USER: begin
        if (w_action == ACT_IRQ || w_action == ACT_EXC) begin
          w_state_next = ST_KERNEL;
        end
      end
      default: begin
        w_state_next = ST_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc <= RESET_VEC;
    end else begin
      r_pc <= w_next_pc;
    end
  end

  // Any control transfer leaves an all-zero bubble in IF/ID for one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_if_id_instr    <= 32'd0;
      r_if_id_pc_plus4 <= 32'd0;
      r_if_id_valid    <= 1'b0;
    end else begin
      case (w_action)
        ACT_SEQ: begin
          r_if_id_instr    <= Instruction;
          r_if_id_pc_plus4 <= w_pc_plus4;
          r_if_id_valid    <= 1'b1;
        end
        ACT_REDIR, ACT_IRQ, ACT_EXC: begin
          r_if_id_instr    <= 32'd0;
          r_if_id_pc_plus4 <= 32'd0;
          r_if_id_valid    <= 1'b0;
        end
        default: begin
          r_if_id_instr    <= r_if_id_instr;
          r_if_id_pc_plus4 <= r_if_id_pc_plus4;
          r_if_id_valid    <= r_if_id_valid;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_epc       <= 32'd0;
      r_epc_write <= 1'b0;
    end else if (w_action == ACT_IRQ || w_action == ACT_EXC) begin
      r_epc       <= w_epc_value;
      r_epc_write <= 1'b1;
    end else begin
      r_epc_write <= 1'b0;
    end
  end

  assign Address           = r_pc;
  assign IF_ID_Instruction = r_if_id_instr;
  assign IF_ID_PCPlus4     = r_if_id_pc_plus4;
  assign IF_ID_Valid       = r_if_id_valid;
  assign EPC               = r_epc;
  assign EPCWrite          = r_epc_write;
  assign KernelMode        = (r_state != ST_USER);

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: behavioural fetch model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_instruction_fetch;

  logic        clk;
  logic        reset;
  logic        Stall;
  logic [1:0]  RedirectSel;
  logic [31:0] BranchTarget;
  logic [31:0] JumpTarget;
  logic [31:0] JrTarget;
  logic        IRQ;
  logic        Exception;
  logic [31:0] Address;
  logic [31:0] Instruction;
  logic [31:0] IF_ID_Instruction;
  logic [31:0] IF_ID_PCPlus4;
  logic        IF_ID_Valid;
  logic [31:0] EPC;
  logic        EPCWrite;
  logic        KernelMode;

  int n_cmp;
  int n_err;

  instruction_fetch dut (
    .clk               (clk),
    .reset             (reset),
    .Stall             (Stall),
    .RedirectSel       (RedirectSel),
    .BranchTarget      (BranchTarget),
    .JumpTarget        (JumpTarget),
    .JrTarget          (JrTarget),
    .IRQ               (IRQ),
    .Exception         (Exception),
    .Address           (Address),
    .Instruction       (Instruction),
    .IF_ID_Instruction (IF_ID_Instruction),
    .IF_ID_PCPlus4     (IF_ID_PCPlus4),
    .IF_ID_Valid       (IF_ID_Valid),
    .EPC               (EPC),
    .EPCWrite          (EPCWrite),
    .KernelMode        (KernelMode)
  );

  // Asynchronous memory: each word holds its own word address.
  assign Instruction = {2'b00, Address[31:2]};

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- behavioural model ----------------
  // mode: 0 = boot, 1 = kernel, 2 = user
  int          m_mode;
  logic [31:0] m_pc, m_ii, m_ip4, m_epc;
  logic        m_v, m_ew;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_mode <= 0;
      m_pc   <= 32'h0;
      m_ii   <= 32'h0;
      m_ip4  <= 32'h0;
      m_v    <= 1'b0;
      m_epc  <= 32'h0;
      m_ew   <= 1'b0;
    end else begin : model_step
      int          mode;
      logic [31:0] pc, ii, ip4, epc, tgt;
      logic        v, ew, squash;
      mode = m_mode; pc = m_pc; ii = m_ii; ip4 = m_ip4; v = m_v; epc = m_epc;
      ew = 1'b0; squash = 1'b0;
      case (RedirectSel)
        2'b01:   tgt = BranchTarget & 32'hFFFF_FFFC;
        2'b10:   tgt = JumpTarget & 32'hFFFF_FFFC;
        2'b11:   tgt = JrTarget & 32'hFFFF_FFFC;
        default: tgt = 32'h0;
      endcase
      if (m_mode == 0) begin
        ii = m_pc >> 2; ip4 = m_pc + 32'd4; v = 1'b1; pc = m_pc + 32'd4; mode = 1;
      end else if (Exception) begin
        epc = m_ip4; ew = 1'b1; squash = 1'b1; pc = 32'h8; mode = 1;
      end else if (IRQ && m_mode == 2) begin
        epc = (RedirectSel != 2'b00) ? tgt : m_pc;
        ew = 1'b1; squash = 1'b1; pc = 32'h4; mode = 1;
      end else if (RedirectSel != 2'b00) begin
        squash = 1'b1; pc = tgt;
        if (RedirectSel == 2'b11) mode = 2;
      end else if (!Stall) begin
        ii = m_pc >> 2; ip4 = m_pc + 32'd4; v = 1'b1; pc = m_pc + 32'd4;
      end
      if (squash) begin
        ii = 32'h0; ip4 = 32'h0; v = 1'b0;
      end
      m_mode <= mode; m_pc <= pc; m_ii <= ii; m_ip4 <= ip4;
      m_v <= v; m_epc <= epc; m_ew <= ew;
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("cyc_Address",   Address, m_pc);
    chk("cyc_IFID_Instr", IF_ID_Instruction, m_ii);
    chk("cyc_IFID_PC4",  IF_ID_PCPlus4, m_ip4);
    chk("cyc_IFID_Valid", {31'd0, IF_ID_Valid}, {31'd0, m_v});
    chk("cyc_EPC",       EPC, m_epc);
    chk("cyc_EPCWrite",  {31'd0, EPCWrite}, {31'd0, m_ew});
    chk("cyc_KernelMode", {31'd0, KernelMode}, {31'd0, (m_mode != 2)});
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    Stall = 1'b0; RedirectSel = 2'b00; IRQ = 1'b0; Exception = 1'b0;
    BranchTarget = 32'h0; JumpTarget = 32'h0; JrTarget = 32'h0;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_Address"}, Address, 32'h0);
    chk({tag, "_IFID_Instr"}, IF_ID_Instruction, 32'h0);
    chk({tag, "_IFID_PC4"}, IF_ID_PCPlus4, 32'h0);
    chk({tag, "_Valid"}, {31'd0, IF_ID_Valid}, 32'd0);
    chk({tag, "_EPC"}, EPC, 32'h0);
    chk({tag, "_EPCWrite"}, {31'd0, EPCWrite}, 32'd0);
    chk({tag, "_Kernel"}, {31'd0, KernelMode}, 32'd1);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    n_cmp = 0;
    n_err = 0;
    idle_inputs();
    reset = 1'b1;
    #1 reset = 1'b0;
    #2 chk_reset_values("por");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("boot_Address", Address, 32'h0);

    // Reset release: 0,4,8,12 with Valid first high after BOOT
    step(); chk("seq1_Address", Address, 32'h4);
    chk("seq1_Valid", {31'd0, IF_ID_Valid}, 32'd1);
    chk("seq1_PC4", IF_ID_PCPlus4, 32'h4);
    step(); chk("seq2_Address", Address, 32'h8);
    chk("seq2_Instr", IF_ID_Instruction, 32'h1);
    step(); chk("seq3_Address", Address, 32'hC);

    // jr from KERNEL into USER
    RedirectSel = 2'b11; JrTarget = 32'h0000_00B8;
    step(); chk("jr_Address", Address, 32'hB8);
    chk("jr_Valid", {31'd0, IF_ID_Valid}, 32'd0);
    chk("jr_User", {31'd0, KernelMode}, 32'd0);
    RedirectSel = 2'b00;
    step(); chk("jr_next_Address", Address, 32'hBC);
    chk("jr_next_Instr", IF_ID_Instruction, 32'h2E);

    // branch with misaligned target, then IRQ in USER at PC 0x100
    RedirectSel = 2'b01; BranchTarget = 32'h0000_0103;
    step(); chk("br_align_Address", Address, 32'h100);
    RedirectSel = 2'b00; IRQ = 1'b1;
    step(); chk("irq_Address", Address, 32'h4);
    chk("irq_EPC", EPC, 32'h100);
    chk("irq_EPCWrite", {31'd0, EPCWrite}, 32'd1);
    chk("irq_Kernel", {31'd0, KernelMode}, 32'd1);
    step(); chk("irq_hold_Address", Address, 32'h8);
    chk("irq_pulse_end", {31'd0, EPCWrite}, 32'd0);
    step();
    RedirectSel = 2'b11; JrTarget = 32'h0000_0200;
    step(); chk("irq_ret_Address", Address, 32'h200);
    RedirectSel = 2'b00;
    step(); chk("irq_retake_Address", Address, 32'h4);
    chk("irq_retake_EPC", EPC, 32'h200);
    IRQ = 1'b0;

    // Exception and IRQ together in USER with IF_ID_PCPlus4 = 0x124
    RedirectSel = 2'b11; JrTarget = 32'h0000_0120;
    step(); RedirectSel = 2'b00;
    step(); chk("exc_pre_PC4", IF_ID_PCPlus4, 32'h124);
    Exception = 1'b1; IRQ = 1'b1;
    step(); chk("exc_Address", Address, 32'h8);
    chk("exc_EPC", EPC, 32'h124);
    Exception = 1'b0;
    step(); chk("exc_irq_pending_Address", Address, 32'hC);
    RedirectSel = 2'b11; JrTarget = 32'h0000_0300;
    step(); RedirectSel = 2'b00;
    step(); chk("exc_irq_taken_Address", Address, 32'h4);
    chk("exc_irq_taken_EPC", EPC, 32'h300);
    IRQ = 1'b0;

    // Exception while in KERNEL
    step(); step();
    Exception = 1'b1;
    step(); chk("kexc_Address", Address, 32'h8);
    chk("kexc_EPC", EPC, 32'hC);
    chk("kexc_Kernel", {31'd0, KernelMode}, 32'd1);
    Exception = 1'b0;

    // Stall for three cycles, then stalled branch
    step();
    Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_Address", Address, 32'hC);
      chk("stall_Instr", IF_ID_Instruction, 32'h2);
    end
    RedirectSel = 2'b01; BranchTarget = 32'h0000_0040;
    step(); chk("stall_br_Address", Address, 32'h40);
    chk("stall_br_Valid", {31'd0, IF_ID_Valid}, 32'd0);
    Stall = 1'b0; RedirectSel = 2'b00;
    step(); chk("stall_br_next", Address, 32'h44);

    // PC wrap at the top of the address space
    RedirectSel = 2'b01; BranchTarget = 32'hFFFF_FFFE;
    step(); chk("wrap_pre", Address, 32'hFFFF_FFFC);
    RedirectSel = 2'b00;
    step(); chk("wrap_Address", Address, 32'h0);
    chk("wrap_PC4", IF_ID_PCPlus4, 32'h0);
    chk("wrap_Instr", IF_ID_Instruction, 32'h3FFF_FFFF);

    // Reset pulsed mid-cycle during a jump
    RedirectSel = 2'b10; JumpTarget = 32'h0000_0500;
    #2 reset = 1'b0;
    #1 chk_reset_values("midrst");
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;
    step(); chk("midrst_resume_Address", Address, 32'h4);
    chk("midrst_resume_Valid", {31'd0, IF_ID_Valid}, 32'd1);
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
